// File: rtl/tour_cmd_sequencer.sv
// rtl/tour_cmd_sequencer.sv - Knight command queue with send/ack/retry sequencing toward RemoteComm
// Optional feature macro: SEQ_PAUSE_EN (adds i_pause input and a PAUSE state)
module tour_cmd_sequencer #(
  parameter int          DEPTH     = 16,
  parameter logic [7:0]  ACK       = 8'hA5,
  parameter logic [23:0] TMO_CYC   = 24'd5000000,
  parameter int          MAX_RETRY = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_wr_cmd,
  input  logic [15:0] i_cmd_in,
  input  logic        i_start,
`ifdef SEQ_PAUSE_EN
  input  logic        i_pause,
`endif
  output logic        o_send_cmd,
  output logic [15:0] o_cmd,
  input  logic        i_cmd_sent,
  input  logic        i_resp_rdy,
  input  logic [7:0]  i_resp,
  output logic        o_full,
  output logic        o_empty,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic [7:0]  o_n_acked
);

  localparam int AW = $clog2(DEPTH);

  // ST_NEXT is the cycle after an ACK pop, where the post-pop queue level decides DONE vs SEND.
`ifdef SEQ_PAUSE_EN
  typedef enum logic [2:0] {
    ST_IDLE, ST_SEND, ST_WAIT_SENT, ST_WAIT_RESP, ST_NEXT, ST_DONE, ST_ERR, ST_PAUSE
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE, ST_SEND, ST_WAIT_SENT, ST_WAIT_RESP, ST_NEXT, ST_DONE, ST_ERR
  } state_t;
`endif

  state_t      r_state;
  state_t      w_state_nxt;
  state_t      w_send_tgt;
  logic [15:0] r_mem [DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic [7:0]  r_retry;
  logic [23:0] r_timer;
  logic [7:0]  r_n_acked;
  logic        w_push;
  logic        w_pop;
  logic        w_full;
  logic        w_empty;
  logic        w_ack;
  logic        w_timeout;
  logic        w_retry_inc;
  logic        w_retry_clr;
  logic        w_cnt_clr;

  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_push    = i_wr_cmd && !w_full;
  assign w_ack     = i_resp_rdy && (i_resp == ACK);
  assign w_timeout = (r_timer == TMO_CYC - 24'd1);

`ifdef SEQ_PAUSE_EN
  assign w_send_tgt = i_pause ? ST_PAUSE : ST_SEND;
`else
  assign w_send_tgt = ST_SEND;
`endif

  assign o_full     = w_full;
  assign o_empty    = w_empty;
  assign o_cmd      = w_empty ? 16'd0 : r_mem[r_rd_ptr[AW-1:0]];
  assign o_send_cmd = (r_state == ST_SEND);
  assign o_busy     = !((r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERR));
  assign o_done     = (r_state == ST_DONE);
  assign o_err      = (r_state == ST_ERR);
  assign o_n_acked  = r_n_acked;

  // Queue storage: written on accepted pushes only, never reset.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_cmd_in;
    end
  end

  // Queue pointers: push and pop are independent so both land in the same cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  // Sequencer state, response timer, retry count and ack counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_timer   <= 24'd0;
      r_retry   <= 8'd0;
      r_n_acked <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= (r_state == ST_WAIT_RESP) ? r_timer + 24'd1 : 24'd0;
      if (w_retry_clr)      r_retry <= 8'd0;
      else if (w_retry_inc) r_retry <= r_retry + 8'd1;
      if (w_cnt_clr)                        r_n_acked <= 8'd0;
      else if (w_pop && r_n_acked != 8'hFF) r_n_acked <= r_n_acked + 8'd1;
    end
  end

  // Next-state and per-cycle control decisions; a response beats a same-cycle timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_retry_inc = 1'b0;
    w_retry_clr = 1'b0;
    w_cnt_clr   = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          if (!w_empty) begin
            w_state_nxt = w_send_tgt;
            w_cnt_clr   = 1'b1;
            w_retry_clr = 1'b1;
          end else begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_SEND:      w_state_nxt = ST_WAIT_SENT;
      ST_WAIT_SENT: if (i_cmd_sent) w_state_nxt = ST_WAIT_RESP;
      ST_WAIT_RESP: begin
        if (w_ack) begin
          w_pop       = 1'b1;
          w_retry_clr = 1'b1;
          w_state_nxt = ST_NEXT;
        end else if (i_resp_rdy || w_timeout) begin
          if (r_retry < 8'(MAX_RETRY)) begin
            w_retry_inc = 1'b1;
            w_state_nxt = w_send_tgt;
          end else begin
            w_state_nxt = ST_ERR;
          end
        end
      end
      ST_NEXT:      w_state_nxt = w_empty ? ST_DONE : w_send_tgt;
      ST_ERR: begin
        if (i_start) begin
          w_retry_clr = 1'b1;
          w_state_nxt = w_send_tgt;
        end
      end
`ifdef SEQ_PAUSE_EN
      ST_PAUSE:     if (!i_pause) w_state_nxt = ST_SEND;
`endif
      default:      w_state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_tour_cmd_sequencer.sv
// tb/tb_tour_cmd_sequencer.sv - randomized self-checking bench for tour_cmd_sequencer
module tb_tour_cmd_sequencer;

  localparam int          DEPTH = 16;
  localparam logic [23:0] TMO   = 24'd100;
  localparam int          MAXR  = 2;

  logic        clk = 1'b0;
  logic        rst, wr, start, cmd_sent, resp_rdy;
  logic [15:0] cmd_in;
  logic [7:0]  resp;
  logic        send_cmd, full, empty, busy, done, err;
  logic [15:0] cmd;
  logic [7:0]  n_acked;
`ifdef SEQ_PAUSE_EN
  logic        pause;
`endif

  always #5 clk = ~clk;

  tour_cmd_sequencer #(.DEPTH(DEPTH), .ACK(8'hA5), .TMO_CYC(TMO), .MAX_RETRY(MAXR)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_wr_cmd(wr), .i_cmd_in(cmd_in), .i_start(start),
`ifdef SEQ_PAUSE_EN
    .i_pause(pause),
`endif
    .o_send_cmd(send_cmd), .o_cmd(cmd), .i_cmd_sent(cmd_sent), .i_resp_rdy(resp_rdy),
    .i_resp(resp), .o_full(full), .o_empty(empty), .o_busy(busy), .o_done(done),
    .o_err(err), .o_n_acked(n_acked)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] q[$];
  int          m_acked = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; wr = 1'b0; start = 1'b0; cmd_sent = 1'b0; resp_rdy = 1'b0;
    cmd_in = 16'd0; resp = 8'd0;
`ifdef SEQ_PAUSE_EN
    pause = 1'b0;
`endif
    tick(); tick();
    rst = 1'b0;
    q.delete();
    m_acked = 0;
  endtask

  task automatic push(input logic [15:0] v);
    wr = 1'b1; cmd_in = v;
    tick();
    wr = 1'b0;
    if (q.size() < DEPTH) q.push_back(v);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    if (q.size() > 0) m_acked = 0;
  endtask

  // Returns the number of clock edges waited before send_cmd was seen.
  task automatic wait_send(output int n, output logic [15:0] c);
    n = 0;
    c = 16'd0;
    while (!send_cmd && n < 300) begin
      tick();
      n++;
    end
    if (!send_cmd) check("send_timeout", {31'd0, send_cmd}, 32'd1);
    else c = cmd;
  endtask

  // RemoteComm behaviour: transmit for a while, then optionally answer.
  task automatic respond(input logic [15:0] c, input logic give, input logic [7:0] r, input logic refill);
    tick();
    check("send_one_cycle", {31'd0, send_cmd}, 32'd0);
    repeat ($urandom_range(0, 3)) tick();
    check("cmd_hold", {16'd0, cmd}, {16'd0, c});
    cmd_sent = 1'b1;
    tick();
    cmd_sent = 1'b0;
    if (give) begin
      if (refill) push(16'($urandom));
      repeat ($urandom_range(0, 6)) tick();
      resp = r; resp_rdy = 1'b1;
      tick();
      resp_rdy = 1'b0; resp = 8'd0;
    end
  endtask

  // Serve sends until the model queue is empty; bad replies only while retries remain.
  task automatic drain(input int bad_pct, input int refill_pct, output int sends);
    int          n;
    int          retry;
    int          exp_lat;
    logic [15:0] c;
    logic [7:0]  r;
    logic        ok;
    sends = 0; retry = 0; exp_lat = 0;
    while (q.size() > 0 && sends < 80) begin
      wait_send(n, c);
      if (!send_cmd) return;
      sends++;
      check("send_latency", n, exp_lat);
      check("cmd_head", {16'd0, c}, {16'd0, q[0]});
      check("busy_in_drain", {31'd0, busy}, 32'd1);
      ok = !(retry < MAXR && int'($urandom_range(0, 99)) < bad_pct);
      r  = 8'($urandom_range(0, 255));
      if (r == 8'hA5) r = 8'h5A;
      if (ok) r = 8'hA5;
      respond(c, 1'b1, r, (int'($urandom_range(0, 99)) < refill_pct) && (q.size() < DEPTH));
      if (ok) begin
        void'(q.pop_front());
        m_acked++;
        retry = 0;
        exp_lat = 1;
      end else begin
        retry++;
        exp_lat = 0;
      end
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n, s;
    logic [15:0] c, c2, v;
    logic        seen;

    // reset values
    do_reset();
    check("rst_send", {31'd0, send_cmd}, 32'd0);
    check("rst_cmd", {16'd0, cmd}, 32'd0);
    check("rst_full", {31'd0, full}, 32'd0);
    check("rst_empty", {31'd0, empty}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_nack", {24'd0, n_acked}, 32'd0);

    // three commands, all acked in order
    push(16'h2000); push(16'h4001); push(16'h6002);
    do_start();
    drain(0, 0, s);
    check("t1_sends", s, 3);
    tick(); tick();
    check("t1_done", {31'd0, done}, 32'd1);
    check("t1_empty", {31'd0, empty}, 32'd1);
    check("t1_nack", {24'd0, n_acked}, 32'd3);
    check("t1_busy", {31'd0, busy}, 32'd0);

    // one bad reply then ACK: same command resent
    v = 16'($urandom);
    push(v);
    do_start();
    wait_send(n, c);
    check("t2_start_lat", n, 0);
    check("t2_cmd", {16'd0, c}, {16'd0, v});
    respond(c, 1'b1, 8'h5A, 1'b0);
    wait_send(n, c2);
    check("t2_retry_lat", n, 0);
    check("t2_same_cmd", {16'd0, c2}, {16'd0, v});
    respond(c2, 1'b1, 8'hA5, 1'b0);
    void'(q.pop_front());
    tick(); tick();
    check("t2_done", {31'd0, done}, 32'd1);
    check("t2_err", {31'd0, err}, 32'd0);
    check("t2_nack", {24'd0, n_acked}, 32'd1);

    // randomized drains with bad replies and refills during the drain
    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(3, 8)) push(16'($urandom));
      do_start();
      drain(30, 25, s);
      tick(); tick();
      check("rnd_done", {31'd0, done}, 32'd1);
      check("rnd_empty", {31'd0, empty}, 32'd1);
      check("rnd_nack", {24'd0, n_acked}, m_acked);
    end

    // no response at all: three sends TMO apart, then err
    v = 16'($urandom);
    push(v);
    do_start();
    for (int k = 0; k < 3; k++) begin
      wait_send(n, c);
      check("t3_lat", n, (k == 0) ? 0 : int'(TMO));
      check("t3_cmd", {16'd0, c}, {16'd0, v});
      respond(c, 1'b0, 8'd0, 1'b0);
    end
    repeat (int'(TMO)) tick();
    check("t3_err", {31'd0, err}, 32'd1);
    check("t3_busy", {31'd0, busy}, 32'd0);
    check("t3_empty", {31'd0, empty}, 32'd0);
    seen = 1'b0;
    repeat (10) begin tick(); seen = seen | send_cmd; end
    check("t3_no_send", {31'd0, seen}, 32'd0);
    do_start();
    wait_send(n, c);
    check("t3_recover_cmd", {16'd0, c}, {16'd0, v});
    check("t3_err_clr", {31'd0, err}, 32'd0);
    respond(c, 1'b1, 8'hA5, 1'b0);
    void'(q.pop_front());
    tick(); tick();
    check("t3_recover_done", {31'd0, done}, 32'd1);

    // overfill: 17th push dropped
    do_reset();
    for (int k = 0; k < 16; k++) push(16'($urandom));
    check("t4_full", {31'd0, full}, 32'd1);
    check("t4_not_empty", {31'd0, empty}, 32'd0);
    push(16'($urandom));
    check("t4_full_after_drop", {31'd0, full}, 32'd1);
    do_start();
    drain(0, 0, s);
    check("t4_sends", s, 16);
    tick(); tick();
    check("t4_nack", {24'd0, n_acked}, 32'd16);
    check("t4_done", {31'd0, done}, 32'd1);

    // reset while waiting for the response
    do_reset();
    push(16'h1234); push(16'h5678);
    do_start();
    wait_send(n, c);
    tick();
    cmd_sent = 1'b1; tick(); cmd_sent = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("t5_send", {31'd0, send_cmd}, 32'd0);
    check("t5_cmd", {16'd0, cmd}, 32'd0);
    check("t5_empty", {31'd0, empty}, 32'd1);
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_nack", {24'd0, n_acked}, 32'd0);
    rst = 1'b0;
    q.delete();
    resp = 8'hA5; resp_rdy = 1'b1; tick(); resp_rdy = 1'b0; resp = 8'd0;
    seen = 1'b0;
    repeat (5) begin tick(); seen = seen | send_cmd; end
    check("t5_late_resp_empty", {31'd0, empty}, 32'd1);
    check("t5_late_resp_nack", {24'd0, n_acked}, 32'd0);
    check("t5_no_send", {31'd0, seen}, 32'd0);

`ifdef SEQ_PAUSE_EN
    // pause after the first ACK holds off the second send
    do_reset();
    push(16'hAAA1); push(16'hBBB2);
    do_start();
    wait_send(n, c);
    pause = 1'b1;
    respond(c, 1'b1, 8'hA5, 1'b0);
    void'(q.pop_front());
    seen = 1'b0;
    repeat (20) begin tick(); seen = seen | send_cmd; end
    check("t6_no_send", {31'd0, seen}, 32'd0);
    check("t6_busy", {31'd0, busy}, 32'd1);
    pause = 1'b0;
    wait_send(n, c);
    check("t6_resume_lat", {31'd0, (n <= 2)}, 32'd1);
    check("t6_cmd", {16'd0, c}, 32'hBBB2);
    respond(c, 1'b1, 8'hA5, 1'b0);
    void'(q.pop_front());
    tick(); tick();
    check("t6_done", {31'd0, done}, 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
